// File: rtl/comm_fifo_pkg.sv
// Shared constants and types for the comm_fpga FIFO bank.
package comm_fifo_pkg;

  localparam int CHAN_W         = 7;
  localparam int BYTE_W         = 8;
  localparam int CTRL_FLUSH_BIT = 7;
  localparam int CTRL_IDX_W     = 4;

  typedef logic [BYTE_W-1:0] byte_t;

endpackage

// File: rtl/comm_fifo_bank_fifo_sync.sv
// First-word-fall-through byte FIFO with occupancy output and synchronous flush.
module fifo_sync
  import comm_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                clk_in,
  input  logic                reset_in,
  input  logic                flush_in,
  input  logic                push_in,
  input  logic [BYTE_W-1:0]   data_in,
  output logic                ready_out,
  input  logic                pop_in,
  output logic [BYTE_W-1:0]   data_out,
  output logic                valid_out,
  output logic [DEPTH_LOG2:0] depth_out
);

  localparam int CAP = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(CAP);

  byte_t                 mem_q [CAP];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  push_ok, pop_ok;

  assign ready_out = (count_q != FULL_CNT);
  assign valid_out = (count_q != '0);
  assign push_ok   = push_in & ready_out;
  assign pop_ok    = pop_in & valid_out;
  // Head is forced to zero when empty so stale storage never leaks out.
  assign data_out  = valid_out ? mem_q[rd_ptr_q] : '0;
  assign depth_out = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_in) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (push_ok && !flush_in) mem_q[wr_ptr_q] <= data_in;
  end

endmodule

// File: rtl/comm_fifo_bank.sv
// Bank of NUM_CHANS host<->application byte FIFO pairs on the comm_fpga channel bus.
// Define COMM_FIFO_BANK_STATUS_EN to add the depth-status and flush-control channels.
module comm_fifo_bank
  import comm_fifo_pkg::*;
#(
  parameter int NUM_CHANS   = 2,
  parameter int DEPTH_LOG2  = 4,
  parameter int BASE_CHAN   = 0,
  parameter int STATUS_CHAN = 64
) (
  input  logic                        clk_in,
  input  logic                        reset_in,
  input  logic [CHAN_W-1:0]           chanAddr_in,
  input  logic [BYTE_W-1:0]           h2fData_in,
  input  logic                        h2fValid_in,
  output logic                        h2fReady_out,
  output logic [BYTE_W-1:0]           f2hData_out,
  output logic                        f2hValid_out,
  input  logic                        f2hReady_in,
  output logic [BYTE_W*NUM_CHANS-1:0] wrData_out,
  output logic [NUM_CHANS-1:0]        wrValid_out,
  input  logic [NUM_CHANS-1:0]        wrReady_in,
  input  logic [BYTE_W*NUM_CHANS-1:0] rdData_in,
  input  logic [NUM_CHANS-1:0]        rdValid_in,
  output logic [NUM_CHANS-1:0]        rdReady_out
);

  localparam int DW = DEPTH_LOG2 + 1;

  logic                              alive_q;
  logic [31:0]                       addr_ext;
  logic [NUM_CHANS-1:0]              pair_sel;
  logic [NUM_CHANS-1:0]              wr_push, wr_not_full;
  logic [NUM_CHANS-1:0]              rd_push, rd_pop, rd_not_full, rd_valid;
  logic [NUM_CHANS-1:0]              flush;
  logic [NUM_CHANS-1:0][BYTE_W-1:0]  rd_head;
  logic [NUM_CHANS-1:0][DW-1:0]      wr_depth, rd_depth;
  logic                              h2f_fire, f2h_fire;
  logic                              stat_hit;
  logic [BYTE_W-1:0]                 stat_data;

  // Holds every ready low until the first edge after reset is released.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) alive_q <= 1'b0;
    else           alive_q <= 1'b1;
  end

  assign addr_ext = 32'(chanAddr_in);
  assign h2f_fire = h2fValid_in & h2fReady_out;
  assign f2h_fire = f2hValid_out & f2hReady_in;

  for (genvar gi = 0; gi < NUM_CHANS; gi++) begin : g_pair
    assign pair_sel[gi] = (addr_ext == 32'(BASE_CHAN + gi));
    assign wr_push[gi]  = h2f_fire & pair_sel[gi];
    assign rd_pop[gi]   = f2h_fire & pair_sel[gi];
    assign rd_push[gi]  = rdValid_in[gi] & alive_q;

    fifo_sync #(.DEPTH_LOG2(DEPTH_LOG2)) u_wr_fifo (
      .clk_in    (clk_in),
      .reset_in  (reset_in),
      .flush_in  (flush[gi]),
      .push_in   (wr_push[gi]),
      .data_in   (h2fData_in),
      .ready_out (wr_not_full[gi]),
      .pop_in    (wrReady_in[gi]),
      .data_out  (wrData_out[BYTE_W*gi +: BYTE_W]),
      .valid_out (wrValid_out[gi]),
      .depth_out (wr_depth[gi])
    );

    fifo_sync #(.DEPTH_LOG2(DEPTH_LOG2)) u_rd_fifo (
      .clk_in    (clk_in),
      .reset_in  (reset_in),
      .flush_in  (flush[gi]),
      .push_in   (rd_push[gi]),
      .data_in   (rdData_in[BYTE_W*gi +: BYTE_W]),
      .ready_out (rd_not_full[gi]),
      .pop_in    (rd_pop[gi]),
      .data_out  (rd_head[gi]),
      .valid_out (rd_valid[gi]),
      .depth_out (rd_depth[gi])
    );
  end

  assign rdReady_out = rd_not_full & {NUM_CHANS{alive_q}};

`ifdef COMM_FIFO_BANK_STATUS_EN
  localparam int CTRL_CHAN = STATUS_CHAN + 2 * NUM_CHANS;

  logic ctrl_hit;

  always_comb begin
    stat_hit  = 1'b0;
    stat_data = '0;
    for (int k = 0; k < NUM_CHANS; k++) begin
      if (addr_ext == 32'(STATUS_CHAN + 2 * k)) begin
        stat_hit  = 1'b1;
        stat_data = BYTE_W'(wr_depth[k]);
      end
      if (addr_ext == 32'(STATUS_CHAN + 2 * k + 1)) begin
        stat_hit  = 1'b1;
        stat_data = BYTE_W'(rd_depth[k]);
      end
    end
  end

  assign ctrl_hit = (addr_ext == 32'(CTRL_CHAN));

  // Indices at or beyond NUM_CHANS never match a generated pair, so they are dropped.
  for (genvar gi = 0; gi < NUM_CHANS; gi++) begin : g_flush
    assign flush[gi] = ctrl_hit & h2f_fire & h2fData_in[CTRL_FLUSH_BIT]
                     & (h2fData_in[CTRL_IDX_W-1:0] == CTRL_IDX_W'(gi));
  end
`else
  logic depth_unused;

  assign stat_hit     = 1'b0;
  assign stat_data    = '0;
  assign flush        = '0;
  assign depth_unused = ^{wr_depth, rd_depth};
`endif

  // Unmapped channels swallow writes and read back zero while out of reset.
  always_comb begin
    h2fReady_out = alive_q;
    f2hValid_out = alive_q;
    f2hData_out  = '0;
    if (stat_hit) f2hData_out = stat_data;
    for (int k = 0; k < NUM_CHANS; k++) begin
      if (pair_sel[k]) begin
        h2fReady_out = alive_q & wr_not_full[k];
        f2hValid_out = alive_q & rd_valid[k];
        f2hData_out  = rd_head[k];
      end
    end
    if (!alive_q) f2hData_out = '0;
  end

endmodule

// File: doc/comm_fifo_bank.md
# comm_fifo_bank

Parametrised bank of NUM_CHANS bidirectional byte FIFO pairs behind the comm_fpga channel interface. It replaces hand-wired single-channel FIFO glue in top levels. Per logical channel k: a write FIFO (host→FPGA, drained by application logic) and a read FIFO (filled by application logic, drained by host). A status/control channel range exposes per-FIFO depths and a per-channel flush.

## Interface
Parameters:
- NUM_CHANS, 2, number of FIFO channel pairs (1..16)
- DEPTH_LOG2, 4, log2 of each FIFO's capacity (1..7; capacity 2..128 bytes)
- BASE_CHAN, 0, first comm channel mapped to FIFO pair 0
- STATUS_CHAN, 64, first status channel; CTRL_CHAN = STATUS_CHAN + 2*NUM_CHANS

Ports:
- clk_in  in  1  sole clock, rising edge
- reset_in  in  1  asynchronous, active-low reset
- chanAddr_in  in  7  currently selected comm channel
- h2fData_in  in  8  host write data
- h2fValid_in  in  1  host write strobe
- h2fReady_out  out  1  bank can accept h2fData_in
- f2hData_out  out  8  host read data
- f2hValid_out  out  1  f2hData_out valid
- f2hReady_in  in  1  host consumes f2hData_out this edge
- wrData_out  out  8*NUM_CHANS  write-FIFO heads, channel k at [8k+7:8k]
- wrValid_out  out  NUM_CHANS  write FIFO k non-empty
- wrReady_in  in  NUM_CHANS  application pops write FIFO k
- rdData_in  in  8*NUM_CHANS  read-FIFO inputs
- rdValid_in  in  NUM_CHANS  application pushes read FIFO k
- rdReady_out  out  NUM_CHANS  read FIFO k not full

## Operation
- Channel decode: chanAddr_in in [BASE_CHAN, BASE_CHAN+NUM_CHANS) selects pair k = chanAddr_in − BASE_CHAN.
- Host write to pair k: push write FIFO k; h2fReady_out = not full(k).
- Host read from pair k: f2hData_out = read-FIFO k head; f2hValid_out = not empty(k); pop on f2hValid_out & f2hReady_in.
- Status read, chanAddr_in = STATUS_CHAN+2k: write-FIFO k depth; STATUS_CHAN+2k+1: read-FIFO k depth. Depth zero-extended to 8 bits; full 128-deep FIFO reads 0x80. f2hValid_out=1.
- Control write, CTRL_CHAN: data[7]=1 flushes both FIFOs of pair data[3:0]; index ≥ NUM_CHANS ignored; data[7]=0 no-op. h2fReady_out=1.
- Any other channel: writes accepted and discarded (h2fReady_out=1); reads return 0x00 with f2hValid_out=1.
- FIFOs are first-word-fall-through; occupancy DEPTH_LOG2+1 bits; pointers DEPTH_LOG2 bits, wrap modulo capacity.
- Push when full: refused (ready low). Pop when empty: no effect (valid low).
- Simultaneous push and pop: depth unchanged; allowed when full only if ready was high, i.e. never; allowed when empty (push lands, pop ignored since valid low).
- Flush beats same-edge application push/pop on that pair; both FIFOs empty after the edge.

## Timing
- Reset (reset_in low, asynchronous): all FIFOs empty; wrValid_out=0, rdReady_out=0, h2fReady_out=0, f2hValid_out=0, f2hData_out=0x00, wrData_out=0. Ready outputs rise one edge after reset_in deasserts. Reset mid-transfer discards all data.
- Push at edge n → head visible, valid high, in cycle n+1.
- Ready/valid/depth are functions of registered state only; no combinational path from wrReady_in/rdValid_in to any output. h2fReady_out and f2hValid_out/f2hData_out depend combinationally on chanAddr_in only.
- Depth reads reflect state after the previous edge.
- Flush takes effect at the edge accepting the control byte.

## Configuration
- COMM_FIFO_BANK_STATUS_EN defined: status and control channels as above.
- Undefined: status/control decode omitted; those addresses behave as unmapped channels (read 0x00, writes discarded); flush unavailable.

## Structure
- Package comm_fifo_pkg: CHAN_W=7, BYTE_W=8, CTRL_FLUSH_BIT=7, CTRL_IDX_W=4.
- Sub-module fifo_sync (DEPTH_LOG2 parameter, FWFT, depth_out, flush_in), instantiated 2*NUM_CHANS times via generate.

## Test plan
- Reset, NUM_CHANS=2, DEPTH_LOG2=4: host writes 0x10..0x1F to chan 0 → h2fReady_out low after 16th byte; read chan 64 → 0x10; wrReady_in[0] pops yield 0x10..0x1F in order.
- Application pushes 0xA0,0xA1 into read FIFO 1; host reads chan 1 → 0xA0,0xA1 then f2hValid_out=0; chan 67 depth reads 0x02 before, 0x00 after.
- Host writes 0x81 to CTRL_CHAN (68) while rdValid_in[1]=1 → pair 1 depths 0x00 next cycle, pair 0 untouched.
- Control byte 0x8F (index 15 ≥ NUM_CHANS) → no depth changes.
- Push/pop write FIFO 0 every cycle for 40 cycles from depth 5 → depth stays 5; data order preserved across pointer wrap.
- Assert reset_in low mid-burst at depth 9 → wrValid_out=0 immediately; after release all depths 0x00; chan 100 read → 0x00.
